// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit controller: state encoding,
// default sample width, underrun policy codes and a saturating counter helper.
package i2s_pkg;

    localparam int I2S_DATA_W = 32;

    localparam int UR_ZEROS  = 0;
    localparam int UR_REPEAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } i2s_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/i2s_pair_fifo.sv
// Synchronous stereo-pair FIFO with occupancy output and a flush that
// empties it in one cycle (flush beats a same-cycle push).
module i2s_pair_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wr_left,
    input  logic [DATA_W-1:0]      wr_right,
    output logic [DATA_W-1:0]      rd_left,
    output logic [DATA_W-1:0]      rd_right,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("i2s_pair_fifo: DEPTH must be a power of 2 and at least 2");
    end

    // Element [0] is the left sample, [1] the right sample.
    logic [1:0][DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   push_ok;
    logic                   pop_ok;

    assign push_ok = push && !flush && (level != LW'(DEPTH));
    assign pop_ok  = pop && (level != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {wr_right, wr_left};
    end

    assign rd_left  = mem[rd_ptr][0];
    assign rd_right = mem[rd_ptr][1];

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: buffers stereo pairs, primes the transmitter,
// feeds it one pair per data request and drains cleanly on stop.
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_W        = I2S_DATA_W,
    parameter int FIFO_DEPTH    = 8,
    parameter int PREFILL       = 2,
    parameter int LOW_WM        = 2,
    parameter int UNDERRUN_MODE = UR_ZEROS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        flush,
    input  logic                        clr_status,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_W-1:0]           wr_left,
    input  logic [DATA_W-1:0]           wr_right,
    output logic                        i2s_enable,
    output logic [DATA_W-1:0]           i2s_data_left,
    output logic [DATA_W-1:0]           i2s_data_right,
    input  logic                        i2s_data_rqst,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        irq_low,
    output logic                        underrun_flag,
    output logic [15:0]                 underrun_cnt
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam bit HOLD_ON_UR = (UNDERRUN_MODE == UR_REPEAT);

    if (PREFILL < 1 || PREFILL > FIFO_DEPTH) begin : g_bad_prefill
        $error("i2s_tx_ctrl: PREFILL must lie in 1..FIFO_DEPTH");
    end

    i2s_state_t        state, state_nxt;
    logic              stop_pending, stop_pending_nxt;
    logic              enable_nxt;
    logic              pop;
    logic              push;
    logic              underrun;
    logic              fifo_flush;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_left;
    logic [DATA_W-1:0] head_right;

    // wr_ready looks at the level before any same-cycle pop.
    assign wr_ready   = fifo_level < LW'(FIFO_DEPTH);
    assign push       = wr_valid && wr_ready;
    assign fifo_flush = flush && (state == ST_IDLE);
    assign fifo_empty = (fifo_level == '0);

    i2s_pair_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .push     (push),
        .pop      (pop),
        .wr_left  (wr_left),
        .wr_right (wr_right),
        .rd_left  (head_left),
        .rd_right (head_right),
        .level    (fifo_level)
    );

    always_comb begin
        state_nxt        = state;
        stop_pending_nxt = stop_pending;
        enable_nxt       = i2s_enable;
        pop              = 1'b0;
        underrun         = 1'b0;
        case (state)
            ST_IDLE: begin
                stop_pending_nxt = 1'b0;
                if (start && !stop) state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (fifo_level >= LW'(PREFILL)) begin
                    pop        = 1'b1;
                    enable_nxt = 1'b1;
                    state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) stop_pending_nxt = 1'b1;
                // An empty FIFO is never bypassed: a same-cycle push is stored, not sent.
                if (i2s_data_rqst) begin
                    if (stop_pending) begin
                        stop_pending_nxt = 1'b0;
                        state_nxt        = ST_DRAIN;
                    end else if (fifo_empty) begin
                        underrun = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Enable is still high on the first drain cycle; use it as the phase bit.
                if (i2s_enable) enable_nxt = 1'b0;
                else            state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            stop_pending <= 1'b0;
            i2s_enable   <= 1'b0;
        end else begin
            state        <= state_nxt;
            stop_pending <= stop_pending_nxt;
            i2s_enable   <= enable_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i2s_data_left  <= '0;
            i2s_data_right <= '0;
        end else if (pop) begin
            i2s_data_left  <= head_left;
            i2s_data_right <= head_right;
        end else if (underrun && !HOLD_ON_UR) begin
            i2s_data_left  <= '0;
            i2s_data_right <= '0;
        end
    end

    // A new underrun wins over a coincident clear, restarting the count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_flag <= 1'b0;
            underrun_cnt  <= '0;
        end else if (underrun) begin
            underrun_flag <= 1'b1;
            underrun_cnt  <= clr_status ? 16'd1 : sat_inc16(underrun_cnt);
        end else if (clr_status) begin
            underrun_flag <= 1'b0;
            underrun_cnt  <= '0;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign irq_low = (state == ST_RUN) && (32'(fifo_level) <= LOW_WM);

endmodule

// File: doc/i2s_tx_ctrl.md
I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one channel sample.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: stereo-pair buffer depth; power of 2, at least 2.
REQ-003 SHALL have parameter PREFILL, default 2: pairs required before streaming starts; range 1..FIFO_DEPTH.
REQ-004 SHALL have parameter LOW_WM, default 2: low-watermark level for the irq_low output.
REQ-005 SHALL have parameter UNDERRUN_MODE, default 0: 0 sends zeros on underrun, 1 repeats the last pair.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: request streaming.
- stop  in  1  one-cycle pulse: request stop at the next frame boundary.
- flush  in  1  one-cycle pulse: empty the FIFO; honoured only in IDLE.
- clr_status  in  1  one-cycle pulse: clear underrun_flag and underrun_cnt.
- wr_valid  in  1  producer has a pair.
- wr_ready  out  1  FIFO not full.
- wr_left  in  DATA_W  left sample.
- wr_right  in  DATA_W  right sample.
- i2s_enable  out  1  drives the transmitter enable.
- i2s_data_left  out  DATA_W  held left sample.
- i2s_data_right  out  DATA_W  held right sample.
- i2s_data_rqst  in  1  transmitter pulse: next pair needed.
- busy  out  1  state is not IDLE.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- irq_low  out  1  RUN and fifo_level <= LOW_WM.
- underrun_flag  out  1  sticky underrun indicator.
- underrun_cnt  out  16  saturating underrun count.

Function
REQ-007 SHALL implement states IDLE, PRIME, RUN and DRAIN.
REQ-008 SHALL leave IDLE for PRIME on start, unless stop is asserted in the same cycle, in which case it stays in IDLE.
REQ-009 SHALL, in PRIME with fifo_level >= PREFILL, pop the head pair into the i2s_data registers, assert i2s_enable on the next cycle and enter RUN.
REQ-010 SHALL return from PRIME to IDLE on stop, with no pop and the FIFO contents retained.
REQ-011 SHALL, in RUN, on i2s_data_rqst with the FIFO non-empty and no stop pending, pop the head pair so that i2s_data_left/right update exactly 1 cycle later and hold until the next pop.
REQ-012 SHALL, in RUN, on i2s_data_rqst with the FIFO empty, load zeros (UNDERRUN_MODE=0) or hold the last pair (UNDERRUN_MODE=1), set underrun_flag and increment underrun_cnt, saturating at 16'hFFFF.
REQ-013 SHALL latch stop in RUN as stop_pending; on the next i2s_data_rqst it SHALL not pop and SHALL enter DRAIN.
REQ-014 SHALL hold i2s_enable high for the first DRAIN cycle, drive it low from the second, then return to IDLE.
REQ-015 SHALL keep i2s_data_left/right unchanged on DRAIN-to-IDLE, and SHALL retain the FIFO contents.
REQ-016 SHALL accept a push when wr_valid && wr_ready; wr_ready = fifo_level < FIFO_DEPTH, evaluated before any same-cycle pop.
REQ-017 SHALL, on same-cycle push and pop, keep fifo_level unchanged.
REQ-018 SHALL not bypass an empty FIFO: a push coinciding with i2s_data_rqst on an empty FIFO is an underrun, and the pushed pair is stored.
REQ-019 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-020 SHALL, on flush in IDLE, set fifo_level to 0 on the next cycle; on same-cycle flush and push, flush wins and the pair is dropped.
REQ-021 SHALL, when clr_status coincides with a new underrun, leave underrun_flag=1 and underrun_cnt=1.
REQ-022 SHALL ignore i2s_data_rqst outside RUN, start outside IDLE, and stop in IDLE and DRAIN.

Reset
REQ-023 SHALL, on rst, enter IDLE and clear the FIFO pointers and stop_pending.
REQ-024 SHALL, on rst, drive i2s_enable=0, i2s_data_left/right=0, busy=0, irq_low=0, underrun_flag=0, underrun_cnt=0 and fifo_level=0.
REQ-025 SHALL let rst mid-stream drop i2s_enable on the next cycle, with no drain.

Structure
REQ-026 SHALL take the state enum, DATA_W default and underrun-mode constants from shared package i2s_pkg.
REQ-027 SHALL implement the buffer as sub-module i2s_pair_fifo: synchronous, with level output and flush input.

Verification
REQ-028 SHALL cover: PREFILL=2; push A,B; start -> i2s_enable rises 1 cycle after the pop of A; outputs = A; fifo_level=1.
REQ-029 SHALL cover: RUN with 1 pair C; two i2s_data_rqst pulses -> first gives outputs = C; second gives zeros, underrun_flag=1, underrun_cnt=1.
REQ-030 SHALL cover: stop mid-frame, then i2s_data_rqst -> no pop; i2s_enable low 2 cycles after the rqst; busy=0 one cycle later.
REQ-031 SHALL cover: full FIFO (8 pairs), wr_valid and rqst in the same cycle -> push rejected (wr_ready=0), pop occurs, fifo_level=7.
REQ-032 SHALL cover: underrun_cnt preloaded to 16'hFFFF, one more underrun -> stays 16'hFFFF; clr_status -> 0.
REQ-033 SHALL cover: rst asserted in RUN -> next cycle i2s_enable=0, fifo_level=0, state IDLE.
